// File: rtl/cmd_queue_pkg.sv
// Shared command-word definitions used by the host queue and the command processor.
package cmd_queue_pkg;

    localparam int unsigned OPC_HI = 63;
    localparam int unsigned OPC_LO = 56;
    localparam int unsigned OPC_W  = OPC_HI - OPC_LO + 1;

    localparam logic [OPC_W-1:0] OPC_HALT = 8'h00;

    function automatic logic is_halt(input logic [OPC_W-1:0] opcode);
        return opcode == OPC_HALT;
    endfunction

endpackage

// File: rtl/cmd_queue_mem.sv
// Command queue storage: one synchronous write port, one asynchronous read port, no reset.
module cmd_queue_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/cmd_queue.sv
// Host-to-command-processor FIFO with first-word-fall-through head, sticky overflow and HALT stop.
module cmd_queue
    import cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    output logic              cmd_valid,
    output logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              halt_seen
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             overflow_nxt;
    logic             halt_seen_nxt;
    logic             host_ready_nxt;
    logic             cmd_valid_nxt;
    logic             push;
    logic             pop;
    logic             mem_we;

    assign push   = host_valid & host_ready;
    assign pop    = cmd_valid & cmd_ready;
    assign mem_we = push & ~flush;

    cmd_queue_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk       (clk),
        .wr_en     (mem_we),
        .wr_addr   (wr_ptr),
        .wr_data   (host_data),
        .rd_addr   (rd_ptr),
        .rd_data_c (cmd_data)
    );

    // Next-state; host_ready/cmd_valid are precomputed so they come straight from flops.
    always_comb begin
        wr_ptr_nxt     = wr_ptr;
        rd_ptr_nxt     = rd_ptr;
        count_nxt      = count;
        overflow_nxt   = overflow;
        halt_seen_nxt  = halt_seen;
        host_ready_nxt = host_ready;
        cmd_valid_nxt  = cmd_valid;

        if (flush) begin
            wr_ptr_nxt     = '0;
            rd_ptr_nxt     = '0;
            count_nxt      = '0;
            overflow_nxt   = 1'b0;
            halt_seen_nxt  = 1'b0;
            host_ready_nxt = 1'b1;
            cmd_valid_nxt  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
            if (host_valid && !host_ready) begin
                overflow_nxt = 1'b1;
            end
            if (pop && is_halt(cmd_data[OPC_HI:OPC_LO])) begin
                halt_seen_nxt = 1'b1;
            end
            host_ready_nxt = (count_nxt != CNT_W'(DEPTH));
            cmd_valid_nxt  = (count_nxt != '0) && !halt_seen_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            halt_seen  <= 1'b0;
            host_ready <= 1'b1;
            cmd_valid  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            overflow   <= overflow_nxt;
            halt_seen  <= halt_seen_nxt;
            host_ready <= host_ready_nxt;
            cmd_valid  <= cmd_valid_nxt;
        end
    end

endmodule

// File: tb/tb_cmd_queue.sv
// Directed-vector bench for cmd_queue (DEPTH=16, DATA_W=64).
module tb_cmd_queue;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned NV     = 12;

    logic              clk;
    logic              rst_n;
    logic              host_valid;
    logic [DATA_W-1:0] host_data;
    logic              host_ready;
    logic              cmd_valid;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_ready;
    logic              flush;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              halt_seen;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        hv;
        logic [63:0] hd;
        logic        cr;
        logic        fl;
        logic        e_hr;
        logic        e_cv;
        logic [63:0] e_cd;
        logic [4:0]  e_cnt;
        logic        e_ovf;
        logic        e_halt;
    } vec_t;

    vec_t vecs [NV];

    cmd_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_valid (host_valid),
        .host_data  (host_data),
        .host_ready (host_ready),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .flush      (flush),
        .count      (count),
        .overflow   (overflow),
        .halt_seen  (halt_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hv, input logic [63:0] hd, input logic cr, input logic fl);
        host_valid = hv;
        host_data  = hd;
        cmd_ready  = cr;
        flush      = fl;
    endtask

    function automatic logic [63:0] ovf_word(input int i);
        return {8'h40, 56'(i)};
    endfunction

    logic [63:0] mq [$];
    int          pushed;
    int          popped;
    logic        m_push;
    logic        m_pop;

    initial begin
        // expected state after the edge that consumes each vector
        vecs[0]  = '{1'b1, 64'h1100_0000_0000_00A1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h1100_0000_0000_00A1, 5'd1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 64'h2200_0000_0000_00B2, 1'b1, 1'b0, 1'b1, 1'b1, 64'h2200_0000_0000_00B2, 5'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 64'h3300_0000_0000_00C3, 1'b1, 1'b0, 1'b1, 1'b1, 64'h3300_0000_0000_00C3, 5'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                   5'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 64'h0100_0000_0000_0001, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0100_0000_0000_0001, 5'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_0000, 5'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 64'h0200_0000_0000_0002, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                   5'd1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 64'h0,                   1'b1, 1'b0, 1'b1, 1'b0, 64'h0,                   5'd1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 64'h7700_0000_0000_00D4, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                   5'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 64'h8800_0000_0000_00E5, 1'b1, 1'b0, 1'b1, 1'b1, 64'h8800_0000_0000_00E5, 5'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 64'h0,                   1'b0, 1'b0, 1'b1, 1'b1, 64'h8800_0000_0000_00E5, 5'd1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 64'h0,                   1'b1, 1'b1, 1'b1, 1'b0, 64'h0,                   5'd0, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        #12;
        check("rst host_ready", 64'(host_ready), 64'd1);
        check("rst cmd_valid",  64'(cmd_valid),  64'd0);
        check("rst count",      64'(count),      64'd0);
        check("rst overflow",   64'(overflow),   64'd0);
        check("rst halt_seen",  64'(halt_seen),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < int'(NV); v++) begin
            drive(vecs[v].hv, vecs[v].hd, vecs[v].cr, vecs[v].fl);
            step();
            check($sformatf("v%0d host_ready", v), 64'(host_ready), 64'(vecs[v].e_hr));
            check($sformatf("v%0d cmd_valid", v),  64'(cmd_valid),  64'(vecs[v].e_cv));
            check($sformatf("v%0d count", v),      64'(count),      64'(vecs[v].e_cnt));
            check($sformatf("v%0d overflow", v),   64'(overflow),   64'(vecs[v].e_ovf));
            check($sformatf("v%0d halt_seen", v),  64'(halt_seen),  64'(vecs[v].e_halt));
            if (vecs[v].e_cv) begin
                check($sformatf("v%0d cmd_data", v), cmd_data, vecs[v].e_cd);
            end
        end

        // fill to 16 with the consumer stalled, then one more word that must be dropped
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, ovf_word(i), 1'b0, 1'b0);
            step();
            check($sformatf("fill%0d count", i),      64'(count),      64'((i < 16) ? i + 1 : 16));
            check($sformatf("fill%0d host_ready", i), 64'(host_ready), 64'(i < 15));
            check($sformatf("fill%0d overflow", i),   64'(overflow),   64'(i == 16));
            check($sformatf("fill%0d head", i),       cmd_data,        ovf_word(0));
        end

        // at full the offered word sees host_ready=0 and is dropped; only the pop happens
        drive(1'b1, 64'h9900_0000_0000_0001, 1'b1, 1'b0);
        step();
        check("full pv count", 64'(count),      64'd15);
        check("full pv head",  cmd_data,        ovf_word(1));
        check("full pv ovf",   64'(overflow),   64'd1);
        check("full pv hr",    64'(host_ready), 64'd1);
        drive(1'b1, 64'h9900_0000_0000_0002, 1'b1, 1'b0);
        step();
        check("pp count", 64'(count), 64'd15);
        check("pp head",  cmd_data,   ovf_word(2));
        drive(1'b0, 64'h0, 1'b0, 1'b1);
        step();
        check("flush count", 64'(count),    64'd0);
        check("flush ovf",   64'(overflow), 64'd0);

        // interleaved push/pop of 20 words through the 16-entry ring
        pushed = 0;
        popped = 0;
        for (int cyc = 0; cyc < 200 && popped < 20; cyc++) begin
            drive((pushed < 20) && (cyc % 4 != 3), {8'hA5, 56'(pushed)}, (cyc % 3 != 0), 1'b0);
            m_push = host_valid && (mq.size() < 16);
            m_pop  = cmd_ready && (mq.size() != 0);
            if (m_pop) begin
                check($sformatf("wrap pop%0d data", popped), cmd_data, mq[0]);
            end
            step();
            if (m_pop) begin
                void'(mq.pop_front());
                popped++;
            end
            if (m_push) begin
                mq.push_back(host_data);
                pushed++;
            end
            check($sformatf("wrap c%0d count", cyc), 64'(count), 64'(mq.size()));
        end
        if (popped != 20) begin
            bad++;
            $display("FAIL wrap drain: popped %0d want 20", popped);
        end
        total++;

        // asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, {8'h5A, 56'(i)}, 1'b0, 1'b0);
            step();
        end
        check("pre-rst count", 64'(count), 64'd3);
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst count",      64'(count),      64'd0);
        check("async rst host_ready", 64'(host_ready), 64'd1);
        check("async rst cmd_valid",  64'(cmd_valid),  64'd0);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 64'h6600_0000_0000_0F0F, 1'b0, 1'b0);
        step();
        check("post-rst valid", 64'(cmd_valid), 64'd1);
        check("post-rst data",  cmd_data,       64'h6600_0000_0000_0F0F);
        check("post-rst count", 64'(count),     64'd1);
        drive(1'b0, 64'h0, 1'b1, 1'b0);
        step();
        check("post-rst drain", 64'(count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
